// File: rtl/pipelined_cache_stage_buf.sv
// In-order DEPTH-entry buffer between tag compare and data access.
// Miss entries wait at the head for their line fill; hit reads pick up older buffered store data.
module pipelined_cache_stage_buf #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5,
  parameter int WAY_W       = 1,
  parameter int DEPTH       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [LINE_WIDTH-1:0]        in_rdata,
  input  logic [LINE_WIDTH-1:0]        in_wdata,
  input  logic [LINE_WIDTH/8-1:0]      in_be,
  input  logic                         in_write,
  input  logic                         in_hit,
  input  logic                         in_dirty,
  input  logic [WAY_W-1:0]             in_way,
  input  logic                         fill_valid,
  input  logic [LINE_WIDTH-1:0]        fill_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [LINE_WIDTH-1:0]        out_rdata,
  output logic [LINE_WIDTH-1:0]        out_wdata,
  output logic [LINE_WIDTH/8-1:0]      out_be,
  output logic                         out_write,
  output logic                         out_hit,
  output logic                         out_dirty,
  output logic [WAY_W-1:0]             out_way,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int BE_W  = LINE_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
  logic [LINE_WIDTH-1:0] r_rdata [DEPTH];
  logic [LINE_WIDTH-1:0] r_wdata [DEPTH];
  logic [BE_W-1:0]       r_be    [DEPTH];
  logic [WAY_W-1:0]      r_way   [DEPTH];
  logic [DEPTH-1:0]      r_write;
  logic [DEPTH-1:0]      r_hit;
  logic [DEPTH-1:0]      r_dirty;
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_resolved;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_enq;
  logic                  w_deq;
  logic                  w_fill;
  logic [LINE_WIDTH-1:0] w_fill_rdata;
  logic [PTR_W-1:0]      w_idx     [DEPTH];
  logic [DEPTH-1:0]      w_fwd_sel;
  logic [LINE_WIDTH-1:0] w_chain   [DEPTH+1];

  function automatic logic [LINE_WIDTH-1:0] f_overlay(
    input logic [LINE_WIDTH-1:0] base,
    input logic [LINE_WIDTH-1:0] data,
    input logic [BE_W-1:0]       be
  );
    logic [LINE_WIDTH-1:0] res;
    res = base;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

  assign in_ready  = rst && (r_count < CNT_W'(DEPTH));
  assign out_valid = r_valid[r_head] && r_resolved[r_head];
  assign w_enq     = in_valid && in_ready && !flush;
  assign w_deq     = out_valid && out_ready && !flush;
  assign w_fill    = fill_valid && r_valid[r_head] && !r_resolved[r_head] && !flush;

  // The head is the oldest entry, so a fill only folds in its own store bytes.
  assign w_fill_rdata = r_write[r_head] ? f_overlay(fill_data, r_wdata[r_head], r_be[r_head])
                                        : fill_data;

  // Walk occupied slots oldest-first so the youngest matching store lands last.
  assign w_chain[0] = in_rdata;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    assign w_idx[gi]     = r_head + PTR_W'(gi);
    assign w_fwd_sel[gi] = (CNT_W'(gi) < r_count) && r_valid[w_idx[gi]] && r_write[w_idx[gi]]
                        && (r_addr[w_idx[gi]][ADDR_WIDTH-1:OFFSET_BITS]
                            == in_addr[ADDR_WIDTH-1:OFFSET_BITS])
                        && (r_way[w_idx[gi]] == in_way);
    assign w_chain[gi+1] = w_fwd_sel[gi]
                         ? f_overlay(w_chain[gi], r_wdata[w_idx[gi]], r_be[w_idx[gi]])
                         : w_chain[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i]  <= '0;
        r_rdata[i] <= '0;
        r_wdata[i] <= '0;
        r_be[i]    <= '0;
        r_way[i]   <= '0;
      end
      r_write    <= '0;
      r_hit      <= '0;
      r_dirty    <= '0;
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (flush) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_enq) begin
        r_addr[r_tail]     <= in_addr;
        r_rdata[r_tail]    <= (!in_write && in_hit) ? w_chain[DEPTH] : in_rdata;
        r_wdata[r_tail]    <= in_wdata;
        r_be[r_tail]       <= in_be;
        r_way[r_tail]      <= in_way;
        r_write[r_tail]    <= in_write;
        r_hit[r_tail]      <= in_hit;
        r_dirty[r_tail]    <= in_dirty;
        r_valid[r_tail]    <= 1'b1;
        r_resolved[r_tail] <= in_hit;
        r_tail             <= r_tail + PTR_W'(1);
      end
      if (w_fill) begin
        r_rdata[r_head]    <= w_fill_rdata;
        r_resolved[r_head] <= 1'b1;
      end
      if (w_deq) begin
        r_valid[r_head]    <= 1'b0;
        r_resolved[r_head] <= 1'b0;
        r_head             <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_addr  = r_addr[r_head];
  assign out_rdata = r_rdata[r_head];
  assign out_wdata = r_wdata[r_head];
  assign out_be    = r_be[r_head];
  assign out_write = r_write[r_head];
  assign out_hit   = r_hit[r_head];
  assign out_dirty = r_dirty[r_head];
  assign out_way   = r_way[r_head];
  assign count     = r_count;

endmodule

// File: tb/tb_pipelined_cache_stage_buf.sv
// Bench for pipelined_cache_stage_buf: directed corner cases, a forwarding vector table,
// and randomized traffic checked against a queue-based reference model.
module tb_pipelined_cache_stage_buf;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int BW = LW / 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [AW-1:0] in_addr = '0;
  logic [LW-1:0] in_rdata = '0;
  logic [LW-1:0] in_wdata = '0;
  logic [BW-1:0] in_be = '0;
  logic in_write = 1'b0;
  logic in_hit = 1'b0;
  logic in_dirty = 1'b0;
  logic [0:0] in_way = '0;
  logic fill_valid = 1'b0;
  logic [LW-1:0] fill_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [LW-1:0] out_rdata;
  logic [LW-1:0] out_wdata;
  logic [BW-1:0] out_be;
  logic out_write;
  logic out_hit;
  logic out_dirty;
  logic [0:0] out_way;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_cache_stage_buf #(
    .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(5), .WAY_W(1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_rdata(in_rdata), .in_wdata(in_wdata), .in_be(in_be),
    .in_write(in_write), .in_hit(in_hit), .in_dirty(in_dirty), .in_way(in_way),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_rdata(out_rdata), .out_wdata(out_wdata), .out_be(out_be),
    .out_write(out_write), .out_hit(out_hit), .out_dirty(out_dirty),
    .out_way(out_way), .count(count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] rdata;
    logic [LW-1:0] wdata;
    logic [BW-1:0] be;
    logic          write;
    logic          hit;
    logic          dirty;
    logic [0:0]    way;
    logic          resolved;
  } ent_t;

  typedef struct {
    logic [AW-1:0] w_addr;
    logic [0:0]    w_way;
    logic [7:0]    w_be;
    logic [63:0]   w_data;
    logic [AW-1:0] r_addr;
    logic [0:0]    r_way;
    logic [63:0]   r_data;
    logic [63:0]   exp_rdata;
  } fwd_vec_t;

  ent_t q[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] ovl(input logic [LW-1:0] base, input logic [LW-1:0] data,
                                        input logic [BW-1:0] be);
    logic [LW-1:0] r;
    r = base;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic enq(input logic [AW-1:0] a, input logic wr, input logic hit, input logic [0:0] way,
                     input logic [BW-1:0] be, input logic [LW-1:0] wd, input logic [LW-1:0] rd);
    chk("enq_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_addr = a; in_write = wr; in_hit = hit; in_way = way;
    in_be = be; in_wdata = wd; in_rdata = rd; in_dirty = 1'b0;
    tick();
    in_valid = 1'b0;
  endtask

  fwd_vec_t vt[4];
  logic [LW-1:0] a5_line;
  logic [LW-1:0] exp_line;
  ent_t ne;
  ent_t hd;
  logic do_enq, do_deq, do_fill, mv;

  initial begin
    vt[0] = '{32'h140, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 32'h144, 1'b1, 64'h0,
              64'h0000_0000_DEAD_BEEF};
    vt[1] = '{32'h140, 1'b1, 8'h0F, 64'h0000_0000_DEAD_BEEF, 32'h144, 1'b0, 64'h0, 64'h0};
    vt[2] = '{32'h140, 1'b1, 8'hFF, 64'hCAFE_F00D_1234_5678, 32'h160, 1'b1,
              64'h1111_1111_2222_2222, 64'h1111_1111_2222_2222};
    vt[3] = '{32'h100, 1'b0, 8'h3C, 64'hAABB_CCDD_EEFF_0011, 32'h11C, 1'b0,
              64'h1234_5678_9ABC_DEF0, 64'h1234_CCDD_EEFF_DEF0};

    // Reset held with traffic presented
    in_valid = 1'b1; in_hit = 1'b1; in_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_count", count, 0);
    end
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_rdata", out_rdata, 0);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1'b1);
    tick();

    // Back-pressure to full, then drain in order
    enq(32'h100, 1'b0, 1'b1, 1'b0, '0, '0, 256'h1);
    enq(32'h200, 1'b0, 1'b1, 1'b0, '0, '0, 256'h2);
    chk("full_count", count, 2);
    chk("full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    chk("drain0_valid", out_valid, 1'b1);
    chk("drain0_addr", out_addr, 32'h100);
    tick();
    chk("drain1_valid", out_valid, 1'b1);
    chk("drain1_addr", out_addr, 32'h200);
    chk("drain1_rdata", out_rdata, 256'h2);
    tick();
    chk("drain_empty", out_valid, 1'b0);
    chk("drain_count", count, 0);
    out_ready = 1'b0;

    // Forwarding vector table
    for (int v = 0; v < 4; v++) begin
      enq(vt[v].w_addr, 1'b1, 1'b1, vt[v].w_way, BW'(vt[v].w_be), LW'(vt[v].w_data), '0);
      enq(vt[v].r_addr, 1'b0, 1'b1, vt[v].r_way, '0, '0, LW'(vt[v].r_data));
      out_ready = 1'b1;
      chk($sformatf("fwd%0d_wr_head", v), {out_valid, out_write, out_addr}, {2'b11, vt[v].w_addr});
      tick();
      chk($sformatf("fwd%0d_rd_head", v), {out_valid, out_write, out_addr}, {2'b10, vt[v].r_addr});
      chk($sformatf("fwd%0d_rdata", v), out_rdata, LW'(vt[v].exp_rdata));
      tick();
      out_ready = 1'b0;
    end

    // Miss held at head until fill
    enq(32'h300, 1'b0, 1'b0, 1'b0, '0, '0, '1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("miss_hold_valid", out_valid, 1'b0);
      tick();
    end
    a5_line = {BW{8'hA5}};
    fill_valid = 1'b1; fill_data = a5_line;
    out_ready = 1'b0;
    tick();
    fill_valid = 1'b0;
    chk("miss_fill_valid", out_valid, 1'b1);
    chk("miss_fill_rdata", out_rdata, a5_line);
    chk("miss_fill_hit", out_hit, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("miss_drained", count, 0);

    // Flush collides with enqueue and fill
    enq(32'h400, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("flush_pre_count", count, 1);
    flush = 1'b1; fill_valid = 1'b1; in_valid = 1'b1; in_addr = 32'h500; in_hit = 1'b1;
    chk("flush_in_ready", in_ready, 1'b1);
    tick();
    flush = 1'b0; fill_valid = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    tick();
    chk("flush_no_ghost", count, 0);

    // Steady enqueue/dequeue at occupancy 1 across pointer wraps
    enq(32'h1000, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_hit = 1'b1; in_write = 1'b0; in_addr = 32'h1000 + (i + 1) * 32'h20;
      chk("stream_addr", {out_valid, out_addr}, {1'b1, 32'h1000 + i * 32'h20});
      tick();
      chk("stream_count", count, 1);
    end
    in_valid = 1'b0;
    chk("stream_last_addr", out_addr, 32'h1100);
    tick();
    chk("stream_empty", count, 0);
    out_ready = 1'b0;

    // Randomized traffic against the queue model
    for (int cyc = 0; cyc < 600; cyc++) begin
      mv = (q.size() > 0) && q[0].resolved;
      chk("rnd_count", count, q.size());
      chk("rnd_in_ready", in_ready, q.size() < DEPTH);
      chk("rnd_out_valid", out_valid, mv);
      if (mv) begin
        chk("rnd_out_addr", out_addr, q[0].addr);
        chk("rnd_out_rdata", out_rdata, q[0].rdata);
        chk("rnd_out_ctl", {out_write, out_hit, out_dirty, out_way, out_be},
            {q[0].write, q[0].hit, q[0].dirty, q[0].way, q[0].be});
        if (q[0].write) chk("rnd_out_wdata", out_wdata, q[0].wdata);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2);
      in_write = 1'($urandom_range(0, 1));
      in_hit = ($urandom_range(0, 3) != 0);
      in_dirty = 1'($urandom_range(0, 1));
      in_way = 1'($urandom_range(0, 1));
      in_be = $urandom;
      in_wdata = rnd_line();
      in_rdata = rnd_line();
      out_ready = ($urandom_range(0, 3) != 0);
      fill_valid = ($urandom_range(0, 3) == 0);
      fill_data = rnd_line();
      flush = ($urandom_range(0, 49) == 0);
      if (flush) begin
        q.delete();
      end else begin
        do_enq = in_valid && (q.size() < DEPTH);
        do_deq = (q.size() > 0) && q[0].resolved && out_ready;
        do_fill = fill_valid && (q.size() > 0) && !q[0].resolved;
        if (do_enq) begin
          ne = '{in_addr, in_rdata, in_wdata, in_be, in_write, in_hit, in_dirty, in_way, in_hit};
          if (!in_write && in_hit) begin
            exp_line = in_rdata;
            foreach (q[k])
              if (q[k].write && (q[k].addr[AW-1:5] == in_addr[AW-1:5]) && (q[k].way == in_way))
                exp_line = ovl(exp_line, q[k].wdata, q[k].be);
            ne.rdata = exp_line;
          end
        end
        if (do_fill) begin
          hd = q[0];
          hd.rdata = hd.write ? ovl(fill_data, hd.wdata, hd.be) : fill_data;
          hd.resolved = 1'b1;
          q[0] = hd;
        end
        if (do_deq) void'(q.pop_front());
        if (do_enq) q.push_back(ne);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
